// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment display path.
// Covers the binary-to-BCD front end and the digit driver it feeds.
package sseg_pkg;

  localparam int BIN_WIDTH  = 14;
  localparam int DEC_MAX    = 9999;
  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: adds 3 to a BCD nibble of 5 or more.
// The add is 4 bits wide, so no carry leaves the nibble.
module bcd_add3
  import sseg_pkg::*;
(
  input  bcd_digit_t value,
  output bcd_digit_t adjusted
);

  assign adjusted = (value >= 4'd5) ? value + 4'd3 : value;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to four-digit BCD converter using shift-and-add-3.
// Digit registers change only on entry to DONE, so the display never sees partial results.
module bin2bcd_seq #(
  parameter int BIN_WIDTH = sseg_pkg::BIN_WIDTH,
  parameter int DEC_MAX   = sseg_pkg::DEC_MAX
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BIN_WIDTH-1:0]   bin,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [3:0]             digit3,
  output logic [3:0]             digit2,
  output logic [3:0]             digit1,
  output logic [3:0]             digit0,
  output sseg_pkg::bcd_state_t   state_dbg
);

  import sseg_pkg::*;

  // The extra top bit absorbs the fifth decimal digit of values above 9999,
  // so the four low nibbles are never corrupted by an out-of-range input.
  localparam int ACC_W = 4 * NUM_DIGITS + 1;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int SR_W  = ACC_W + BIN_WIDTH;

  bcd_state_t           state_q, state_d;
  logic [ACC_W-1:0]     acc_q;
  logic [BIN_WIDTH-1:0] shr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_pend_q;

  logic [ACC_W-1:0]     acc_adj;
  logic [SR_W-1:0]      sr_cur;
  logic [SR_W-1:0]      sr_next;
  logic [ACC_W-1:0]     acc_next;
  logic [BIN_WIDTH-1:0] shr_next;
  logic                 capture;
  logic                 step;
  logic                 last_step;
  logic                 finish;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .value    (acc_q[4*g +: 4]),
      .adjusted (acc_adj[4*g +: 4])
    );
  end
  assign acc_adj[ACC_W-1] = acc_q[ACC_W-1];

  assign sr_cur              = {acc_adj, shr_q};
  assign sr_next             = sr_cur << 1;
  assign acc_next            = sr_next[SR_W-1 -: ACC_W];
  assign shr_next            = sr_next[BIN_WIDTH-1:0];

  // Handshake: start is a request accepted on any edge where the FSM is in IDLE
  // or DONE (busy low); done is a one-cycle response marking the digits valid.
  assign capture   = start && ((state_q == IDLE) || (state_q == DONE));
  assign step      = (state_q == SHIFT);
  assign last_step = (cnt_q == CNT_W'(1));
  assign finish    = step && last_step;
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      shr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
    end else if (capture) begin
      acc_q      <= '0;
      shr_q      <= bin;
      cnt_q      <= CNT_W'(BIN_WIDTH);
      ovf_pend_q <= (int'(bin) > DEC_MAX);
    end else if (step) begin
      acc_q      <= acc_next;
      shr_q      <= shr_next;
      cnt_q      <= cnt_q - CNT_W'(1);
    end
  end

  // Saturation comes from the compare taken at capture, not the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit3   <= '0;
      digit2   <= '0;
      digit1   <= '0;
      digit0   <= '0;
      overflow <= 1'b0;
    end else if (finish) begin
      overflow <= ovf_pend_q;
      if (ovf_pend_q) begin
        digit3 <= 4'd9;
        digit2 <= 4'd9;
        digit1 <= 4'd9;
        digit0 <= 4'd9;
      end else begin
        digit3 <= acc_next[15:12];
        digit2 <= acc_next[11:8];
        digit1 <= acc_next[7:4];
        digit0 <= acc_next[3:0];
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a driver pushes expected results into a queue,
// a monitor pops and compares on every done pulse.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin = '0;
  logic        busy, done, overflow;
  logic [3:0]  digit3, digit2, digit1, digit0;
  sseg_pkg::bcd_state_t state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];

  bin2bcd_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .digit3    (digit3),
    .digit2    (digit2),
    .digit1    (digit1),
    .digit0    (digit0),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [16:0] ref_model(input int v);
    if (v > 9999) return {1'b1, 16'h9999};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] dut_result();
    return 32'({overflow, digit3, digit2, digit1, digit0});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int   busy_run = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        check("done_width", 32'(prev_done), 32'd0);
        check("busy_cycles", 32'(busy_run), 32'd14);
        busy_run = 0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got result %0h expected no done at %0t",
                   dut_result(), $time);
        end else begin
          check("result", dut_result(), 32'(exp_q.pop_front()));
        end
      end
      prev_done = done;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the start was accepted.
  task automatic start_conv(input int v);
    int guard = 0;
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      n_cmp++;
      n_err++;
      $display("FAIL start_timeout: busy stuck high for %0d cycles, required low", guard);
    end
    start = 1'b1;
    bin   = v[13:0];
    @(posedge clk);
    exp_q.push_back(ref_model(v));
    #1;
    start = 1'b0;
    bin   = 14'($urandom);
    @(negedge clk);
  endtask

  // Returns at the negedge where done is seen.
  task automatic wait_done();
    int guard = 0;
    while (!done && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no done after %0d cycles, required within 16", guard);
    end
  endtask

  // ---------------- stimulus ----------------
  int bound_vals[12] = '{0, 1, 9, 10, 99, 100, 999, 1000, 9998, 9999, 10000, 16383};

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("reset_result", dut_result(), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(sseg_pkg::IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // basic conversion
    start_conv(1234);
    wait_done();

    // back-to-back with start held in DONE
    start_conv(0);
    wait_done();
    start_conv(9999);
    wait_done();

    // saturation, then recovery
    start_conv(10000);
    wait_done();
    start_conv(16383);
    wait_done();
    start_conv(42);
    wait_done();

    // start during SHIFT is ignored, digits hold the previous result
    start_conv(5678);
    wait_done();
    start_conv(305);
    repeat (3) @(negedge clk);
    start = 1'b1;
    bin   = 14'd1111;
    @(negedge clk);
    start = 1'b0;
    check("hold_mid_conv", dut_result(), 32'(ref_model(5678)));
    wait_done();

    // reset mid-conversion
    start_conv(8888);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("abort_result", dut_result(), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(state_dbg), 32'(sseg_pkg::IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    start_conv(4321);
    wait_done();

    // boundaries
    foreach (bound_vals[i]) begin
      start_conv(bound_vals[i]);
      wait_done();
    end

    // random sweep, mixing back-to-back and idle gaps
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      start_conv(int'($urandom_range(0, 16383)));
      wait_done();
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
